alu_nibble_sequencer: RTL

- Multi-nibble operation sequencer sitting directly upstream of the 4-bit ALU slice.
- Latches two wide operands and a function code, then presents one nibble per clock to the slice's A/B/F/COM/carry inputs.
- Captures each returned result nibble and threads the slice's carry outputs back into the next nibble's carry input.
- Accumulates the wide result and wide status flags (zero, neg-zero, equal, carry-out) for the surrounding datapath.

---
 rtl/alu_nibble_sequencer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/alu_nibble_sequencer.sv
// alu_nibble_sequencer: runs a wide ALU operation through a 4-bit slice one nibble per clock,
// chaining slice carries and accumulating the wide result and status flags.
module alu_nibble_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [2:0]             func,
  input  logic                   com,
  input  logic                   cin,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   carry_out,
  output logic                   zero,
  output logic                   neg_zero,
  output logic                   equ,
  output logic [3:0]             alu_a,
  output logic [3:0]             alu_b,
  output logic [2:0]             alu_f,
  output logic                   alu_com,
  output logic                   alu_ci_right,
  output logic                   alu_ci_left,
  input  logic [3:0]             alu_d,
  input  logic                   alu_co_left,
  input  logic                   alu_co_right,
  input  logic                   alu_zero,
  input  logic                   alu_neg_zero,
  input  logic                   alu_equ
);
  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t                   state_q, state_d;
  logic [IW-1:0]            cnt_q, cnt_d, pos;
  logic [2:0]               func_q, func_d;
  logic                     com_q, com_d, chain_q, chain_d, carry_q, carry_d;
  logic                     zero_q, zero_d, nz_q, nz_d, equ_q, equ_d;
  logic [NIBBLES-1:0][3:0]  a_q, a_d, b_q, b_d, res_q, res_d;
  logic                     run, accept, last, shr, co;
  assign run    = state_q == RUN;
  assign accept = start && !run;
  assign last   = cnt_q == LAST;
  assign shr    = func_q == 3'd6;
  // SHR walks from the top nibble down so the fill bit can ripple rightwards
  assign pos    = shr ? LAST - cnt_q : cnt_q;
  assign co     = shr ? alu_co_right : alu_co_left;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      func_q  <= '0;
      com_q   <= 1'b0;
      chain_q <= 1'b0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      nz_q    <= 1'b0;
      equ_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      func_q  <= func_d;
      com_q   <= com_d;
      chain_q <= chain_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      nz_q    <= nz_d;
      equ_q   <= equ_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end
  always_comb begin
    state_d = accept ? RUN : run ? (last ? DONE : RUN) : IDLE;
  end
  always_comb begin
    cnt_d   = cnt_q;
    func_d  = func_q;
    com_d   = com_q;
    chain_d = chain_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    nz_d    = nz_q;
    equ_d   = equ_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    if (accept) begin
      func_d  = func;
      com_d   = com;
      chain_d = cin;
      a_d     = op_a;
      b_d     = op_b;
      cnt_d   = '0;
      zero_d  = 1'b1;
      nz_d    = 1'b1;
      equ_d   = 1'b1;
    end else if (run) begin
      res_d[pos] = alu_d;
      chain_d    = co;
      zero_d     = zero_q & alu_zero;
      nz_d       = nz_q & alu_neg_zero;
      equ_d      = equ_q & alu_equ;
      cnt_d      = cnt_q + 1'b1;
      carry_d    = last ? ((func_q == 3'd0 || func_q[2:1] == 2'b11) & co) : carry_q;
    end
  end
  always_comb begin
    busy         = run;
    done         = state_q == DONE;
    result       = res_q;
    carry_out    = carry_q;
    zero         = zero_q;
    neg_zero     = nz_q;
    equ          = equ_q;
    alu_a        = run ? a_q[pos] : 4'h0;
    alu_b        = run ? b_q[pos] : 4'h0;
    alu_f        = func_q;
    alu_com      = com_q;
    alu_ci_right = run & ~shr & chain_q;
    alu_ci_left  = run & shr & chain_q;
  end
endmodule
